// File: rtl/atm_pkg.sv
// Shared types for the ATM PIN authentication path: request ops, status codes
// and the authenticator FSM states.
package atm_pkg;

  typedef enum logic {
    OP_AUTH  = 1'b0,
    OP_CHPIN = 1'b1
  } auth_op_e;

  typedef enum logic [2:0] {
    OK        = 3'd0,
    NOT_FOUND = 3'd1,
    BAD_PIN   = 3'd2,
    LOCKED    = 3'd3,
    SAME_PIN  = 3'd4
  } auth_stat_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2,
    RESP   = 2'd3
  } auth_state_e;

endpackage

// File: rtl/pin_auth_engine_if.sv
// Request/response handshake bundle between the ATM control FSM (master) and
// the PIN authenticator (slave).
interface pin_auth_engine_if #(
  parameter int ACC_W = 11,
  parameter int PIN_W = 16,
  parameter int IDX_W = 4
);
  logic                 req_valid;
  logic                 req_ready;
  atm_pkg::auth_op_e    req_op;
  logic [ACC_W-1:0]     req_acc;
  logic [PIN_W-1:0]     req_pin;
  logic [PIN_W-1:0]     req_new_pin;
  logic                 rsp_valid;
  logic                 rsp_ready;
  atm_pkg::auth_stat_e  rsp_status;
  logic [IDX_W-1:0]     rsp_idx;

  modport master (
    output req_valid, req_op, req_acc, req_pin, req_new_pin, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_idx
  );

  modport slave (
    input  req_valid, req_op, req_acc, req_pin, req_new_pin, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_idx
  );
endinterface

// File: rtl/pin_db_store.sv
// Account/PIN register database: load port, PIN update port and per-entry
// read mux addressed by the engine's search index.
module pin_db_store #(
  parameter int NUM_ACCOUNTS = 10,
  parameter int ACC_W        = 11,
  parameter int PIN_W        = 16,
  parameter int IDX_W        = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [ACC_W-1:0] wr_acc,
  input  logic [PIN_W-1:0] wr_pin,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [PIN_W-1:0] upd_pin,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [ACC_W-1:0] rd_acc,
  output logic [PIN_W-1:0] rd_pin
);
  logic [NUM_ACCOUNTS-1:0] valid_q;
  logic [ACC_W-1:0]        acc_q [NUM_ACCOUNTS];
  logic [PIN_W-1:0]        pin_q [NUM_ACCOUNTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        acc_q[i] <= '0;
        pin_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        if (wr_en && wr_idx == IDX_W'(i)) begin
          valid_q[i] <= 1'b1;
          acc_q[i]   <= wr_acc;
          pin_q[i]   <= wr_pin;
        end else if (upd_en && upd_idx == IDX_W'(i)) begin
          pin_q[i] <= upd_pin;
        end
      end
    end
  end

  // Out-of-range indices read as an empty entry.
  always_comb begin
    rd_valid = 1'b0;
    rd_acc   = '0;
    rd_pin   = '0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_valid = valid_q[i];
        rd_acc   = acc_q[i];
        rd_pin   = pin_q[i];
      end
    end
  end
endmodule

// File: rtl/pin_auth_engine.sv
// Sequential account/PIN authenticator with optional per-account lockout
// (enabled by defining PIN_AUTH_LOCKOUT_EN).
//   state  | meaning
//   IDLE   | accepting requests and database loads
//   SEARCH | comparing entry idx against the latched account
//   CHECK  | evaluating lock / PIN / op for the matched entry
//   RESP   | holding the response until rsp_ready
module pin_auth_engine
  import atm_pkg::*;
#(
  parameter  int NUM_ACCOUNTS = 10,
  parameter  int ACC_W        = 11,
  parameter  int PIN_W        = 16,
  parameter  int MAX_TRIES    = 3,
  localparam int IDX_W        = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             db_wr_en,
  input  logic [IDX_W-1:0] db_wr_idx,
  input  logic [ACC_W-1:0] db_wr_acc,
  input  logic [PIN_W-1:0] db_wr_pin,
  pin_auth_engine_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCOUNTS - 1);

  if (NUM_ACCOUNTS < 2 || MAX_TRIES < 1) begin : g_param_check
    $error("pin_auth_engine: NUM_ACCOUNTS must be >= 2 and MAX_TRIES >= 1");
  end

  auth_state_e      state, state_nxt;
  logic             ready_en;
  logic [IDX_W-1:0] idx;
  auth_op_e         op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q, new_pin_q;
  auth_stat_e       rsp_status_q, chk_status;
  logic [IDX_W-1:0] rsp_idx_q;
  logic             rd_valid, hit, pin_ok, locked_now, db_we, upd_en, hs;
  logic [ACC_W-1:0] rd_acc;
  logic [PIN_W-1:0] rd_pin;

  assign bus.req_ready  = ready_en && (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_idx    = rsp_idx_q;

  assign hs     = bus.req_valid && ready_en && (state == IDLE);
  assign db_we  = db_wr_en && (state == IDLE);
  assign hit    = rd_valid && (rd_acc == acc_q);
  assign pin_ok = (rd_pin == pin_q);
  assign upd_en = (state == CHECK) && !locked_now && pin_ok &&
                  (op_q == OP_CHPIN) && (new_pin_q != pin_q);

  pin_db_store #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS), .ACC_W(ACC_W), .PIN_W(PIN_W), .IDX_W(IDX_W)
  ) u_store (
    .clk(clk), .rst_n(rst_n),
    .wr_en(db_we), .wr_idx(db_wr_idx), .wr_acc(db_wr_acc), .wr_pin(db_wr_pin),
    .upd_en(upd_en), .upd_idx(idx), .upd_pin(new_pin_q),
    .rd_idx(idx), .rd_valid(rd_valid), .rd_acc(rd_acc), .rd_pin(rd_pin)
  );

`ifdef PIN_AUTH_LOCKOUT_EN
  localparam int CNT_W = $clog2(MAX_TRIES + 1);
  logic [CNT_W-1:0]        fail_cnt [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q;

  always_comb begin
    locked_now = 1'b0;
    for (int i = 0; i < NUM_ACCOUNTS; i++)
      if (idx == IDX_W'(i)) locked_now = lock_q[i];
  end

  // A locked entry freezes its counter, so the count never passes MAX_TRIES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) fail_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        if (db_we && db_wr_idx == IDX_W'(i)) begin
          fail_cnt[i] <= '0;
          lock_q[i]   <= 1'b0;
        end else if (state == CHECK && idx == IDX_W'(i) && !lock_q[i]) begin
          if (!pin_ok) begin
            if (fail_cnt[i] != CNT_W'(MAX_TRIES)) fail_cnt[i] <= fail_cnt[i] + CNT_W'(1);
            if (fail_cnt[i] == CNT_W'(MAX_TRIES - 1)) lock_q[i] <= 1'b1;
          end else begin
            fail_cnt[i] <= '0;
          end
        end
      end
    end
  end
`else
  assign locked_now = 1'b0;
`endif

  always_comb begin
    if (locked_now)             chk_status = LOCKED;
    else if (!pin_ok)           chk_status = BAD_PIN;
    else if (op_q == OP_AUTH)   chk_status = OK;
    else if (new_pin_q == pin_q) chk_status = SAME_PIN;
    else                        chk_status = OK;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = SEARCH;
      SEARCH:  if (hit) state_nxt = CHECK;
               else if (idx == LAST_IDX) state_nxt = RESP;
      CHECK:   state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en     <= 1'b0;
      idx          <= '0;
      op_q         <= OP_AUTH;
      acc_q        <= '0;
      pin_q        <= '0;
      new_pin_q    <= '0;
      rsp_status_q <= OK;
      rsp_idx_q    <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: if (hs) begin
          idx       <= '0;
          op_q      <= bus.req_op;
          acc_q     <= bus.req_acc;
          pin_q     <= bus.req_pin;
          new_pin_q <= bus.req_new_pin;
        end
        SEARCH: if (!hit) begin
          if (idx == LAST_IDX) begin
            rsp_status_q <= NOT_FOUND;
            rsp_idx_q    <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        CHECK: begin
          rsp_status_q <= chk_status;
          rsp_idx_q    <= idx;
        end
        default: ;
      endcase
    end
  end
endmodule
